fetch_unit: RTL and testbench

- Instruction fetch stage that sits directly upstream of the decode/register-file/data-memory path inside TopLevel.
- Owns the program counter and drives the instruction ROM address.
- Registers the 9-bit instruction word for the downstream stages and applies branch redirects.
- Implements the Start/Ack program-launch handshake that the top-level bench drives: Start held high then released launches the program; Ack flags the halt.

---
 rtl/fetch_unit.sv | 129 ++++++++++++
 tb/tb_fetch_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, ROM address, branch redirect, Start/Ack launch (optional FETCH_CYCLE_CNT_EN cycle counter)
module fetch_unit #(
    parameter int              PW         = 10,
    parameter int              IW         = 9,
    parameter logic [IW-1:0]   HALT_OP    = 9'h1FF,
    parameter logic [PW-1:0]   START_ADDR = '0
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Stall,
    input  logic          BranchEn,
    input  logic [PW-1:0] Target,
    input  logic [IW-1:0] InstIn,
    output logic [PW-1:0] InstAddr,
    output logic [IW-1:0] Inst,
    output logic          InstValid,
`ifdef FETCH_CYCLE_CNT_EN
    output logic [15:0]   CycleCnt,
`endif
    output logic          Ack
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    localparam logic [PW-1:0] PC_ONE = {{(PW-1){1'b0}}, 1'b1};

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] pc_q, pc_d;
    logic [IW-1:0] inst_q, inst_d;
    logic          valid_q, valid_d;
    logic          ack_q, ack_d;

    // Next-state: Start overrides everything; in RUN a stall freezes the
    // stage, a valid HALT_OP wins over a branch, and a taken branch
    // squashes the word fetched in the same cycle.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        valid_d = valid_q;
        ack_d   = ack_q;
        if (Start) begin
            state_d = ST_IDLE;
            pc_d    = START_ADDR;
            valid_d = 1'b0;
            ack_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_RUN;
                    inst_d  = InstIn;
                    valid_d = 1'b1;
                    pc_d    = START_ADDR + PC_ONE;
                end
                ST_RUN: begin
                    if (!Stall) begin
                        if (valid_q && (inst_q == HALT_OP)) begin
                            state_d = ST_HALT;
                            ack_d   = 1'b1;
                            valid_d = 1'b0;
                        end else if (valid_q && BranchEn) begin
                            pc_d    = Target;
                            inst_d  = '0;
                            valid_d = 1'b0;
                        end else begin
                            inst_d  = InstIn;
                            valid_d = 1'b1;
                            pc_d    = pc_q + PC_ONE;
                        end
                    end
                end
                default: begin
                    state_d = ST_HALT;
                end
            endcase
        end
    end

    // Stage registers with asynchronous reset to the pre-launch state.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            pc_q    <= START_ADDR;
            inst_q  <= '0;
            valid_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
            ack_q   <= ack_d;
        end
    end

    assign InstAddr  = pc_q;
    assign Inst      = inst_q;
    assign InstValid = valid_q;
    assign Ack       = ack_q;

`ifdef FETCH_CYCLE_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Counts every RUN cycle (stalls and bubbles included), saturating.
    always_comb begin
        cnt_d = cnt_q;
        if (Start) begin
            cnt_d = '0;
        end else if ((state_q == ST_RUN) && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Counter register, cleared with the rest of the stage.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign CycleCnt = cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized and directed bench for fetch_unit against a program-level reference
module tb_fetch_unit;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0;
    logic       Stall = 1'b0;
    logic       BranchEn = 1'b0;
    logic [9:0] Target = '0;
    logic [8:0] InstIn;
    logic [9:0] InstAddr;
    logic [8:0] Inst;
    logic       InstValid;
    logic       Ack;
`ifdef FETCH_CYCLE_CNT_EN
    logic [15:0] CycleCnt;
`endif

    logic [8:0] rom [0:1023];
    assign InstIn = rom[InstAddr];

    fetch_unit dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall),
        .BranchEn(BranchEn), .Target(Target), .InstIn(InstIn),
        .InstAddr(InstAddr), .Inst(Inst), .InstValid(InstValid),
`ifdef FETCH_CYCLE_CNT_EN
        .CycleCnt(CycleCnt),
`endif
        .Ack(Ack)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: "launched" / "halted" flags plus the program position.
    bit         launched, halted;
    int         m_pc;
    int         m_inst;
    bit         m_inst_known;
    bit         m_valid, m_ack;
    int         m_cnt;

    task automatic model_reset();
        launched = 0; halted = 0; m_pc = 0; m_inst = 0; m_inst_known = 1;
        m_valid = 0; m_ack = 0; m_cnt = 0;
    endtask

    task automatic model_step(input bit st, input bit sl, input bit br, input int tg);
        if (st) begin
            launched = 0; halted = 0; m_pc = 0; m_valid = 0; m_ack = 0;
            m_cnt = 0; m_inst_known = 0;
        end else if (!launched) begin
            launched = 1; m_inst = rom[0]; m_inst_known = 1; m_valid = 1; m_pc = 1;
        end else if (!halted) begin
            if (m_cnt < 65535) m_cnt++;
            if (!sl) begin
                if (m_valid && m_inst == 'h1FF) begin
                    halted = 1; m_ack = 1; m_valid = 0;
                end else if (m_valid && br) begin
                    m_pc = tg; m_inst = 0; m_valid = 0;
                end else begin
                    m_inst = rom[m_pc]; m_valid = 1; m_pc = (m_pc + 1) % 1024;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".addr"}, 32'(InstAddr), 32'(m_pc));
        chk({tag, ".valid"}, 32'(InstValid), 32'(m_valid));
        chk({tag, ".ack"}, 32'(Ack), 32'(m_ack));
        if (m_inst_known) chk({tag, ".inst"}, 32'(Inst), 32'(m_inst));
`ifdef FETCH_CYCLE_CNT_EN
        chk({tag, ".cnt"}, 32'(CycleCnt), 32'(m_cnt));
`endif
    endtask

    task automatic step(input bit st, input bit sl, input bit br, input int tg);
        Start = st; Stall = sl; BranchEn = br; Target = 10'(tg);
        model_step(st, sl, br, tg);
        @(posedge Clk);
        #1;
        check_all("step");
    endtask

    task automatic launch();
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
    endtask

    task automatic run_to_addr(input int a);
        for (int k = 0; k < 200 && int'(InstAddr) != a; k++) step(0, 0, 0, 0);
        chk("reach_addr", 32'(InstAddr), 32'(a));
    endtask

    task automatic run_to_ack();
        for (int k = 0; k < 200 && !Ack; k++) step(0, 0, 0, 0);
        chk("reach_ack", 32'(Ack), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            rom[i] = 9'($urandom);
            if (rom[i] == 9'h1FF) rom[i] = 9'h000;
        end
        rom[0] = 9'h010; rom[1] = 9'h011; rom[2] = 9'h012; rom[3] = 9'h1FF;
        model_reset();
        #2;
        check_all("reset");
        #8;
        Reset = 1'b0;

        // Launch: 010, 011, 012 then halt with InstAddr=4
        launch();
        chk("launch.i0", 32'(Inst), 32'h010);
        step(0, 0, 0, 0);
        chk("launch.i1", 32'(Inst), 32'h011);
        step(0, 0, 0, 0);
        chk("launch.i2", 32'(Inst), 32'h012);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("halt.ack", 32'(Ack), 32'd1);
        chk("halt.addr", 32'(InstAddr), 32'd4);
        chk("halt.valid", 32'(InstValid), 32'd0);
        step(0, 0, 1, 'h55);
        step(0, 1, 0, 0);
        chk("halt.hold", 32'(InstAddr), 32'd4);

        // Restart from halt with a single Start pulse
        step(1, 0, 0, 0);
        chk("restart.ack", 32'(Ack), 32'd0);
        chk("restart.addr", 32'(InstAddr), 32'd0);
        step(0, 0, 0, 0);
        run_to_ack();

        // Branch at ROM[5] to 0x040: one bubble then ROM[0x40]
        rom[3] = 9'h013;
        launch();
        run_to_addr(6);
        step(0, 0, 1, 'h040);
        chk("br.addr", 32'(InstAddr), 32'h040);
        chk("br.bubble", 32'(InstValid), 32'd0);
        step(0, 0, 0, 0);
        chk("br.tgt", 32'(Inst), 32'(rom['h40]));
        chk("br.tvalid", 32'(InstValid), 32'd1);

        // Stall three cycles at InstAddr=7, with a branch ignored meanwhile
        launch();
        run_to_addr(7);
        step(0, 1, 0, 0);
        step(0, 1, 1, 'h100);
        step(0, 1, 0, 0);
        chk("stall.addr", 32'(InstAddr), 32'd7);
        step(0, 0, 0, 0);
        chk("stall.resume", 32'(Inst), 32'(rom[7]));

        // Wrap from 0x3FF to 0 without a bubble
        rom[10'h3FF] = 9'h000;
        step(0, 0, 1, 'h3FF);
        step(0, 0, 0, 0);
        chk("wrap.addr", 32'(InstAddr), 32'd0);
        step(0, 0, 0, 0);
        chk("wrap.inst", 32'(Inst), 32'(rom[0]));
        chk("wrap.valid", 32'(InstValid), 32'd1);

        // Asynchronous reset mid-run at InstAddr=0x12
        for (int i = 0; i < 'h40; i++) if (rom[i] == 9'h1FF) rom[i] = 9'h001;
        launch();
        run_to_addr('h12);
        #2;
        Reset = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Reset = 1'b0;

        // Cycle count: 3 instructions + halt with one stall
        rom[0] = 9'h010; rom[1] = 9'h011; rom[2] = 9'h012; rom[3] = 9'h1FF;
        launch();
        step(0, 1, 0, 0);
        run_to_ack();
`ifdef FETCH_CYCLE_CNT_EN
        chk("cnt.five", 32'(CycleCnt), 32'd5);
        step(0, 0, 0, 0);
        chk("cnt.frozen", 32'(CycleCnt), 32'd5);
`endif

        // Random program with sprinkled halts, branches, stalls, restarts
        for (int i = 0; i < 1024; i++) begin
            rom[i] = 9'($urandom);
            if (rom[i] == 9'h1FF) rom[i] = 9'h000;
            if ($urandom_range(31) == 0) rom[i] = 9'h1FF;
        end
        for (int k = 0; k < 3000; k++) begin
            bit st, sl, br;
            st = Ack ? ($urandom_range(3) == 0) : ($urandom_range(99) == 0);
            sl = ($urandom_range(3) == 0);
            br = ($urandom_range(7) == 0);
            step(st, sl, br, int'($urandom_range(1023)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
